// File: rtl/esc_sched_pkg.sv
// Shared types, widths and default timing constants for the ESC frame scheduler.
package esc_sched_pkg;

  localparam int SPD_W              = 11;
  localparam int FRAME_CLKS_DEF     = 125000;
  localparam int ARM_FRAMES_DEF     = 50;
  localparam int TIMEOUT_FRAMES_DEF = 20;
  localparam logic [SPD_W-1:0] IDLE_SPD_DEF = 11'd100;

  typedef logic [SPD_W-1:0] spd_t;

  typedef enum logic [1:0] {
    IDLE,
    ARMING,
    RUN
  } state_t;

  // Clamp a commanded speed up to the running floor (plain unsigned compare).
  function automatic spd_t floor_spd(input spd_t spd, input spd_t min_spd);
    return (spd < min_spd) ? min_spd : spd;
  endfunction

endpackage

// File: rtl/esc_frame_timer.sv
// Free-running frame counter 0..FRAME_CLKS-1 with synchronous clear; flags the last count.
module esc_frame_timer
  import esc_sched_pkg::*;
#(
  parameter int FRAME_CLKS = FRAME_CLKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic boundary
);

  localparam int              CNT_W = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_CLKS - 1);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || boundary) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign boundary = (cnt == LAST);

endmodule

// File: rtl/esc_frame_sched.sv
// Frame scheduler feeding four ESC interfaces: arming sequence, idle floor and stale-command failsafe.
module esc_frame_sched
  import esc_sched_pkg::*;
#(
  parameter int         FRAME_CLKS     = FRAME_CLKS_DEF,
  parameter int         ARM_FRAMES     = ARM_FRAMES_DEF,
  parameter int         TIMEOUT_FRAMES = TIMEOUT_FRAMES_DEF,
  parameter logic [SPD_W-1:0] IDLE_SPD = IDLE_SPD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             spd_vld,
  input  logic [SPD_W-1:0] frnt_spd,
  input  logic [SPD_W-1:0] bck_spd,
  input  logic [SPD_W-1:0] lft_spd,
  input  logic [SPD_W-1:0] rght_spd,
  output logic [SPD_W-1:0] frnt_spd_q,
  output logic [SPD_W-1:0] bck_spd_q,
  output logic [SPD_W-1:0] lft_spd_q,
  output logic [SPD_W-1:0] rght_spd_q,
  output logic             wrt,
  output logic             armed,
  output logic             stale
);

  localparam int                 ARM_W     = $clog2(ARM_FRAMES + 1);
  localparam logic [ARM_W-1:0]   ARM_LAST  = ARM_W'(ARM_FRAMES - 1);
  localparam int                 STALE_W   = $clog2(TIMEOUT_FRAMES + 1);
  localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_FRAMES);

  state_t             state, state_nxt;
  logic               boundary, load, enter_arming;
  logic [ARM_W-1:0]   arm_cnt;
  logic [STALE_W-1:0] stale_cnt;
  spd_t [3:0]         shadow, spd_q, spd_nxt;

  esc_frame_timer #(.FRAME_CLKS(FRAME_CLKS)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state == IDLE),
    .boundary (boundary)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE:   if (arm) state_nxt = ARMING;
      ARMING: begin
        if (!arm) begin
          state_nxt = IDLE;
        end else if (boundary) begin
          load = 1'b1;
          if (arm_cnt == ARM_LAST) state_nxt = RUN;
        end
      end
      RUN: begin
        if (!arm)          state_nxt = IDLE;
        else if (boundary) load = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign enter_arming = (state == IDLE) && arm;
  assign stale        = (stale_cnt == STALE_MAX);
  assign armed        = (state == RUN);

  // ARMING frames carry zero; stale RUN frames carry zero with no idle floor.
  always_comb begin
    spd_nxt = '0;
    if (state == RUN && !stale) begin
      for (int i = 0; i < 4; i++) spd_nxt[i] = floor_spd(shadow[i], IDLE_SPD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_cnt   <= '0;
      stale_cnt <= '0;
    end else begin
      if (enter_arming)                 arm_cnt <= '0;
      else if (state == ARMING && load) arm_cnt <= arm_cnt + 1'b1;

      if (enter_arming || spd_vld)                 stale_cnt <= '0;
      else if (boundary && stale_cnt != STALE_MAX) stale_cnt <= stale_cnt + 1'b1;
    end
  end

  // NOTE: the shadow bank is only 4 words and its power-up value is visible
  // as a speed, so it is reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (spd_vld) begin
      shadow <= {frnt_spd, bck_spd, lft_spd, rght_spd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spd_q <= '0;
      wrt   <= 1'b0;
    end else if (!arm) begin
      spd_q <= '0;
      wrt   <= 1'b0;
    end else if (load) begin
      spd_q <= spd_nxt;
      wrt   <= 1'b1;
    end else begin
      wrt   <= 1'b0;
    end
  end

  assign frnt_spd_q = spd_q[3];
  assign bck_spd_q  = spd_q[2];
  assign lft_spd_q  = spd_q[1];
  assign rght_spd_q = spd_q[0];

endmodule
